// File: rtl/refill_engine.sv
// Instruction-cache miss refill engine: victim pick, burst fetch, early restart, tag commit.
// Define MISS_HANDLER_CWF_EN to request the critical beat first (wrap burst); default is in-order.
module refill_engine #(
  parameter int TAG_W           = 8,
  parameter int SET_W           = 4,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int WORD_W          = 20,
  parameter int BEAT_WORDS      = 2,
  parameter int NUM_WAYS        = 4,
  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK),
  localparam int BEATS   = WORDS_PER_BLOCK / BEAT_WORDS,
  localparam int BEAT_W  = $clog2(BEATS),
  localparam int WAY_W   = $clog2(NUM_WAYS),
  localparam int ADDR_W  = TAG_W + SET_W + OFF_W,
  localparam int BEAT_DW = BEAT_WORDS * WORD_W
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               i_halt,
  input  logic               i_miss_valid,
  output logic               o_miss_ready,
  input  logic [TAG_W-1:0]   i_miss_tag,
  input  logic [SET_W-1:0]   i_miss_set,
  input  logic [OFF_W-1:0]   i_miss_offset,
  input  logic [NUM_WAYS-1:0] i_way_valid,
  input  logic [WAY_W-1:0]   i_lru_way,
  output logic               o_mem_req_valid,
  input  logic               i_mem_req_ready,
  output logic [ADDR_W-1:0]  o_mem_req_addr,
  input  logic               i_mem_rsp_valid,
  output logic               o_mem_rsp_ready,
  input  logic [BEAT_DW-1:0] i_mem_rsp_data,
  output logic               o_da_wr_valid,
  input  logic               i_da_wr_ready,
  output logic [SET_W-1:0]   o_da_wr_set,
  output logic [WAY_W-1:0]   o_da_wr_way,
  output logic [BEAT_W-1:0]  o_da_wr_beat,
  output logic [BEAT_DW-1:0] o_da_wr_data,
  output logic               o_tag_wr_valid,
  input  logic               i_tag_wr_ready,
  output logic [SET_W-1:0]   o_tag_wr_set,
  output logic [WAY_W-1:0]   o_tag_wr_way,
  output logic [TAG_W-1:0]   o_tag_wr_tag,
  output logic [WORD_W-1:0]  o_missed_word,
  output logic               o_missed_word_valid,
  output logic               o_busy
);

  localparam int WSEL_W = $clog2(BEAT_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, FILL, TAG} state_t;
  state_t state;

  logic [TAG_W-1:0]  tag_q;
  logic [SET_W-1:0]  set_q;
  logic [OFF_W-1:0]  off_q;
  logic [WAY_W-1:0]  way_q;
  logic [BEAT_W-1:0] crit_q, start_q, cnt;
  logic              last_rx, mw_pend;

  logic [WAY_W-1:0]  victim;
  logic [BEAT_W-1:0] crit_in, start_in, beat_idx;
  logic [OFF_W-1:0]  start_off;
  logic [WORD_W-1:0] crit_word;
  logic              miss_fire, req_fire, rsp_fire, da_fire, tag_fire;

  // Lowest invalid way wins; a fully valid set falls back to LRU.
  always_comb begin
    victim = i_lru_way;
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (!i_way_valid[w]) victim = WAY_W'(w);
  end

  assign crit_in = BEAT_W'(i_miss_offset >> WSEL_W);
`ifdef MISS_HANDLER_CWF_EN
  assign start_in = crit_in;
`else
  assign start_in = '0;
`endif
  assign start_off = OFF_W'(start_in) << WSEL_W;
  assign beat_idx  = start_q + cnt;

  always_comb begin
    crit_word = '0;
    for (int w = 0; w < BEAT_WORDS; w++)
      if (OFF_W'(w) == (off_q & OFF_W'(BEAT_WORDS-1)))
        crit_word = i_mem_rsp_data[w*WORD_W +: WORD_W];
  end

  assign o_miss_ready        = (state == IDLE) & ~i_halt;
  // A beat is taken only when the write slot is free or draining this cycle.
  assign o_mem_rsp_ready     = (state == FILL) & ~last_rx & ~i_halt & (~o_da_wr_valid | i_da_wr_ready);
  assign o_missed_word_valid = mw_pend & ~i_halt;
  assign o_busy              = (state != IDLE);
  assign o_da_wr_set         = set_q;
  assign o_da_wr_way         = way_q;
  assign o_tag_wr_set        = set_q;
  assign o_tag_wr_way        = way_q;
  assign o_tag_wr_tag        = tag_q;

  assign miss_fire = o_miss_ready & i_miss_valid;
  assign req_fire  = o_mem_req_valid & i_mem_req_ready & ~i_halt;
  assign rsp_fire  = o_mem_rsp_ready & i_mem_rsp_valid;
  assign da_fire   = o_da_wr_valid & i_da_wr_ready & ~i_halt;
  assign tag_fire  = o_tag_wr_valid & i_tag_wr_ready & ~i_halt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state           <= IDLE;
      tag_q           <= '0;
      set_q           <= '0;
      off_q           <= '0;
      way_q           <= '0;
      crit_q          <= '0;
      start_q         <= '0;
      cnt             <= '0;
      last_rx         <= 1'b0;
      mw_pend         <= 1'b0;
      o_mem_req_valid <= 1'b0;
      o_mem_req_addr  <= '0;
      o_da_wr_valid   <= 1'b0;
      o_da_wr_beat    <= '0;
      o_da_wr_data    <= '0;
      o_tag_wr_valid  <= 1'b0;
      o_missed_word   <= '0;
    end else if (!i_halt) begin
      mw_pend <= 1'b0;
      case (state)
        IDLE: if (miss_fire) begin
          tag_q           <= i_miss_tag;
          set_q           <= i_miss_set;
          off_q           <= i_miss_offset;
          way_q           <= victim;
          crit_q          <= crit_in;
          start_q         <= start_in;
          o_mem_req_addr  <= {i_miss_tag, i_miss_set, start_off};
          o_mem_req_valid <= 1'b1;
          state           <= REQ;
        end
        REQ: if (req_fire) begin
          o_mem_req_valid <= 1'b0;
          cnt             <= '0;
          last_rx         <= 1'b0;
          state           <= FILL;
        end
        FILL: begin
          if (rsp_fire) begin
            o_da_wr_valid <= 1'b1;
            o_da_wr_beat  <= beat_idx;
            o_da_wr_data  <= i_mem_rsp_data;
            cnt           <= cnt + 1'b1;
            if (cnt == BEAT_W'(BEATS-1)) last_rx <= 1'b1;
            if (beat_idx == crit_q) begin
              o_missed_word <= crit_word;
              mw_pend       <= 1'b1;
            end
          end else if (da_fire) begin
            o_da_wr_valid <= 1'b0;
            if (last_rx) begin
              o_tag_wr_valid <= 1'b1;
              state          <= TAG;
            end
          end
        end
        TAG: if (tag_fire) begin
          o_tag_wr_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_refill_engine.sv
// Directed bench for refill_engine: memory responder, transaction-level model and per-cycle compare.
`timescale 1ns/1ps
module tb_refill_engine;
  localparam int TAG_W = 8, SET_W = 4, WPB = 16, WORD_W = 20, BW = 2, NW = 4;
  localparam int OFF_W = 4, BEATS = 8, BEAT_W = 3, WAY_W = 2, ADDR_W = 16, BEAT_DW = 40;
`ifdef MISS_HANDLER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk, arst_n, i_halt;
  logic i_miss_valid, o_miss_ready;
  logic [TAG_W-1:0] i_miss_tag;
  logic [SET_W-1:0] i_miss_set;
  logic [OFF_W-1:0] i_miss_offset;
  logic [NW-1:0] i_way_valid;
  logic [WAY_W-1:0] i_lru_way;
  logic o_mem_req_valid, i_mem_req_ready;
  logic [ADDR_W-1:0] o_mem_req_addr;
  logic i_mem_rsp_valid, o_mem_rsp_ready;
  logic [BEAT_DW-1:0] i_mem_rsp_data;
  logic o_da_wr_valid, i_da_wr_ready;
  logic [SET_W-1:0] o_da_wr_set;
  logic [WAY_W-1:0] o_da_wr_way;
  logic [BEAT_W-1:0] o_da_wr_beat;
  logic [BEAT_DW-1:0] o_da_wr_data;
  logic o_tag_wr_valid, i_tag_wr_ready;
  logic [SET_W-1:0] o_tag_wr_set;
  logic [WAY_W-1:0] o_tag_wr_way;
  logic [TAG_W-1:0] o_tag_wr_tag;
  logic [WORD_W-1:0] o_missed_word;
  logic o_missed_word_valid, o_busy;

  refill_engine dut (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
    .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready),
    .i_miss_tag(i_miss_tag), .i_miss_set(i_miss_set), .i_miss_offset(i_miss_offset),
    .i_way_valid(i_way_valid), .i_lru_way(i_lru_way),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_rsp_valid(i_mem_rsp_valid), .o_mem_rsp_ready(o_mem_rsp_ready), .i_mem_rsp_data(i_mem_rsp_data),
    .o_da_wr_valid(o_da_wr_valid), .i_da_wr_ready(i_da_wr_ready), .o_da_wr_set(o_da_wr_set),
    .o_da_wr_way(o_da_wr_way), .o_da_wr_beat(o_da_wr_beat), .o_da_wr_data(o_da_wr_data),
    .o_tag_wr_valid(o_tag_wr_valid), .i_tag_wr_ready(i_tag_wr_ready), .o_tag_wr_set(o_tag_wr_set),
    .o_tag_wr_way(o_tag_wr_way), .o_tag_wr_tag(o_tag_wr_tag),
    .o_missed_word(o_missed_word), .o_missed_word_valid(o_missed_word_valid), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: each word names its own tag, set, beat and word slot.
  function automatic logic [WORD_W-1:0] mem_word(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s,
                                                 input int b, input int w);
    return {t, s, 4'(b), 4'(w)};
  endfunction

  function automatic logic [BEAT_DW-1:0] mem_beat(input logic [TAG_W-1:0] t, input logic [SET_W-1:0] s,
                                                  input int b);
    logic [BEAT_DW-1:0] d;
    d = '0;
    for (int w = 0; w < BW; w++) d[w*WORD_W +: WORD_W] = mem_word(t, s, b, w);
    return d;
  endfunction

  // Zero-latency memory: returns BEATS beats in wrap order from the requested beat.
  logic [TAG_W-1:0] m_tag;
  logic [SET_W-1:0] m_set;
  int m_next, m_left;
  initial begin
    m_left = 0; m_next = 0; m_tag = '0; m_set = '0;
    i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) m_left = 0;
      else begin
        if (i_mem_rsp_valid && o_mem_rsp_ready) begin
          m_left--; m_next = (m_next + 1) % BEATS;
        end
        if (o_mem_req_valid && i_mem_req_ready && !i_halt) begin
          m_tag  = o_mem_req_addr[ADDR_W-1 -: TAG_W];
          m_set  = o_mem_req_addr[OFF_W +: SET_W];
          m_next = int'(o_mem_req_addr[OFF_W-1:0]) / BW;
          m_left = BEATS;
        end
      end
      @(posedge clk); #1;
      i_mem_rsp_valid = (m_left > 0);
      i_mem_rsp_data  = (m_left > 0) ? mem_beat(m_tag, m_set, m_next) : '0;
    end
  end

  // Transaction-level model state.
  int cyc = 0;
  bit outst, req_done, mw_pm, e_rr, req_f, rsp_f, da_f, tag_f, miss_f;
  int acc_cnt, pend, e_crit, e_start, e_widx, vsel;
  logic [TAG_W-1:0] e_tag;
  logic [SET_W-1:0] e_set;
  logic [WAY_W-1:0] e_way;
  logic [ADDR_W-1:0] e_addr, rec_addr;
  int wq[$];
  int acc_cyc, mw_cyc, first_beat, n_wr, mw_pulses;
  logic [WORD_W-1:0] mw_val;
  logic [WAY_W-1:0] last_way;

  initial begin
    outst = 0; req_done = 0; mw_pm = 0; acc_cnt = 0; pend = 0;
    e_crit = 0; e_start = 0; e_widx = 0; e_tag = '0; e_set = '0; e_way = '0; e_addr = '0;
    rec_addr = '0; acc_cyc = 0; mw_cyc = 0; first_beat = -1; n_wr = 0; mw_pulses = 0;
    mw_val = '0; last_way = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!arst_n) begin
        outst = 0; req_done = 0; mw_pm = 0; acc_cnt = 0; pend = 0; wq.delete();
        chk("rst_miss_ready", o_miss_ready, !i_halt);
        chk("rst_busy", o_busy, 0);
        chk("rst_req_valid", o_mem_req_valid, 0);
        chk("rst_req_addr", o_mem_req_addr, 0);
        chk("rst_rsp_ready", o_mem_rsp_ready, 0);
        chk("rst_da_valid", o_da_wr_valid, 0);
        chk("rst_da_data", o_da_wr_data, 0);
        chk("rst_da_beat", o_da_wr_beat, 0);
        chk("rst_tag_valid", o_tag_wr_valid, 0);
        chk("rst_tag", {o_tag_wr_tag, o_tag_wr_set, o_tag_wr_way}, 0);
        chk("rst_mw_valid", o_missed_word_valid, 0);
        chk("rst_mw", o_missed_word, 0);
        continue;
      end
      e_rr = outst && req_done && acc_cnt < BEATS && !i_halt && (pend == 0 || i_da_wr_ready);
      chk("miss_ready", o_miss_ready, !outst && !i_halt);
      chk("busy", o_busy, outst);
      chk("req_valid", o_mem_req_valid, outst && !req_done);
      if (o_mem_req_valid) chk("req_addr", o_mem_req_addr, e_addr);
      chk("rsp_ready", o_mem_rsp_ready, e_rr);
      chk("da_valid", o_da_wr_valid, pend > 0);
      if (o_da_wr_valid && wq.size() > 0) begin
        chk("da_beat", o_da_wr_beat, wq[0]);
        chk("da_data", o_da_wr_data, mem_beat(e_tag, e_set, wq[0]));
        chk("da_way", o_da_wr_way, e_way);
        chk("da_set", o_da_wr_set, e_set);
      end
      chk("tag_valid", o_tag_wr_valid, outst && req_done && acc_cnt == BEATS && pend == 0);
      if (o_tag_wr_valid) chk("tag_fields", {o_tag_wr_tag, o_tag_wr_set, o_tag_wr_way}, {e_tag, e_set, e_way});
      chk("mw_valid", o_missed_word_valid, mw_pm && !i_halt);
      if (o_missed_word_valid) begin
        chk("mw_word", o_missed_word, mem_word(e_tag, e_set, e_crit, e_widx));
        mw_val = o_missed_word; mw_cyc = cyc; mw_pulses++;
      end

      miss_f = o_miss_ready && i_miss_valid;
      req_f  = o_mem_req_valid && i_mem_req_ready && !i_halt;
      rsp_f  = i_mem_rsp_valid && o_mem_rsp_ready;
      da_f   = o_da_wr_valid && i_da_wr_ready && !i_halt;
      tag_f  = o_tag_wr_valid && i_tag_wr_ready && !i_halt;
      if (!i_halt) mw_pm = 0;
      if (req_f) begin req_done = 1; rec_addr = o_mem_req_addr; end
      if (rsp_f) begin
        if ((e_start + acc_cnt) % BEATS == e_crit) mw_pm = 1;
        acc_cnt++; pend++;
      end
      if (da_f) begin
        if (wq.size() == 0) chk("da_extra_write", 1, 0);
        else void'(wq.pop_front());
        if (n_wr == 0) first_beat = int'(o_da_wr_beat);
        last_way = o_da_wr_way; n_wr++; pend--;
      end
      if (tag_f) outst = 0;
      if (miss_f) begin
        e_tag = i_miss_tag; e_set = i_miss_set;
        vsel = -1;
        for (int w = 0; w < NW; w++) if (!i_way_valid[w] && vsel < 0) vsel = w;
        e_way   = (vsel < 0) ? i_lru_way : WAY_W'(vsel);
        e_crit  = int'(i_miss_offset) / BW;
        e_widx  = int'(i_miss_offset) % BW;
        e_start = CWF ? e_crit : 0;
        e_addr  = {i_miss_tag, i_miss_set, OFF_W'(e_start * BW)};
        wq.delete();
        for (int k = 0; k < BEATS; k++) wq.push_back((e_start + k) % BEATS);
        outst = 1; req_done = 0; acc_cnt = 0; pend = 0; mw_pm = 0;
        acc_cyc = cyc; first_beat = -1; n_wr = 0; mw_pulses = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_miss(input logic [7:0] t, input logic [3:0] s, input logic [3:0] o,
                          input logic [3:0] wv, input logic [1:0] lru);
    i_miss_valid = 1'b1; i_miss_tag = t; i_miss_set = s; i_miss_offset = o;
    i_way_valid = wv; i_lru_way = lru;
    tick();
    i_miss_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (outst && n < 300) begin tick(); n++; end
    chk(name, n < 300, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    arst_n = 1'b0; i_halt = 1'b0; i_miss_valid = 1'b0; i_miss_tag = '0; i_miss_set = '0;
    i_miss_offset = '0; i_way_valid = '0; i_lru_way = '0;
    i_mem_req_ready = 1'b1; i_da_wr_ready = 1'b1; i_tag_wr_ready = 1'b1;
    tick(); tick();
    arst_n = 1'b1;
    tick();

    // A: full set, LRU victim, critical word in beat 5 slot 1
    run_miss(8'hA5, 4'h3, 4'hB, 4'b1111, 2'd2);
    wait_idle("A_done");
    chk("A_req_addr", rec_addr, CWF ? 16'hA53A : 16'hA530);
    chk("A_first_beat", first_beat, CWF ? 5 : 0);
    chk("A_way", last_way, 2);
    chk("A_mw", mw_val, 20'hA5351);
    chk("A_mw_latency", mw_cyc - acc_cyc, CWF ? 3 : 8);
    chk("A_writes", n_wr, 8);
    chk("A_pulses", mw_pulses, 1);
    tick();

    // B: first invalid way is 2
    run_miss(8'hA5, 4'h3, 4'hB, 4'b1011, 2'd0);
    wait_idle("B_done");
    chk("B_way", last_way, 2);
    chk("B_writes", n_wr, 8);
    tick();

    // C: data-array back-pressure mid-burst, last beat holds the critical word
    run_miss(8'h3C, 4'hF, 4'hF, 4'b0111, 2'd1);
    repeat (3) tick();
    i_da_wr_ready = 1'b0;
    repeat (3) tick();
    i_da_wr_ready = 1'b1;
    wait_idle("C_done");
    chk("C_way", last_way, 3);
    chk("C_writes", n_wr, 8);
    chk("C_first_beat", first_beat, CWF ? 7 : 0);
    chk("C_mw", mw_val, 20'h3CF71);
    chk("C_pulses", mw_pulses, 1);
    tick();

    // D: halt during FILL (delays the early-restart pulse) and during TAG
    i_tag_wr_ready = 1'b0;
    run_miss(8'h12, 4'h7, 4'h4, 4'b0000, 2'd3);
    tick(); tick();
    i_halt = 1'b1;
    repeat (4) tick();
    i_halt = 1'b0;
    n = 0;
    while (!o_tag_wr_valid && n < 100) begin tick(); n++; end
    chk("D_tag_wait", n < 100, 1);
    tick();
    i_halt = 1'b1; i_tag_wr_ready = 1'b1;
    repeat (4) begin tick(); chk("D_tag_hold", o_tag_wr_valid, 1); end
    i_halt = 1'b0;
    wait_idle("D_done");
    chk("D_way", last_way, 0);
    chk("D_writes", n_wr, 8);
    chk("D_mw", mw_val, 20'h12720);
    chk("D_mw_latency", mw_cyc - acc_cyc, CWF ? 7 : 9);
    chk("D_pulses", mw_pulses, 1);
    tick();

    // E: reset mid-burst, then a fresh miss
    run_miss(8'hA5, 4'h3, 4'hB, 4'b1111, 2'd2);
    repeat (5) tick();
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    #1;
    chk("E_ready_after_rst", o_miss_ready, 1);
    tick();
    run_miss(8'h5A, 4'hC, 4'h1, 4'b1101, 2'd3);
    wait_idle("E_done");
    chk("E_way", last_way, 1);
    chk("E_writes", n_wr, 8);
    chk("E_mw", mw_val, 20'h5AC01);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/refill_engine.md
# refill_engine

Parametrised cache-miss refill engine for the instruction cache, sitting between the lookup pipeline and the external memory interface. It accepts one miss at a time and picks the victim way: the first invalid way, otherwise the supplied LRU way. It fetches the block as a burst of multi-word beats, writes each beat into the data array as it arrives, and forwards the missed word as soon as its beat lands (early restart). It then commits the tag/status entry. It generalises the fixed 4-way/16-word/40-bit-beat miss path to arbitrary geometry and adds ready/valid back-pressure on every interface.

## Interface
Parameters (derived: OFF_W=clog2(WORDS_PER_BLOCK), BEATS=WORDS_PER_BLOCK/BEAT_WORDS, BEAT_W=clog2(BEATS), WAY_W=clog2(NUM_WAYS), ADDR_W=TAG_W+SET_W+OFF_W, BEAT_DW=BEAT_WORDS*WORD_W):
- TAG_W, 8, tag bits
- SET_W, 4, set index bits
- WORDS_PER_BLOCK, 16, words per block; power of 2
- WORD_W, 20, instruction word width
- BEAT_WORDS, 2, words per memory beat; power of 2, ≤ WORDS_PER_BLOCK
- NUM_WAYS, 4, associativity; power of 2, ≥2

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- i_halt  in  1  global stall; freezes all state
- i_miss_valid / o_miss_ready  in/out  1  miss request handshake
- i_miss_tag, i_miss_set, i_miss_offset  in  TAG_W, SET_W, OFF_W  missed address
- i_way_valid  in  NUM_WAYS  valid bits of the missed set
- i_lru_way  in  WAY_W  LRU way of the missed set
- o_mem_req_valid / i_mem_req_ready  out/in  1  burst request handshake
- o_mem_req_addr  out  ADDR_W  beat-aligned start address
- i_mem_rsp_valid / o_mem_rsp_ready  in/out  1  beat handshake
- i_mem_rsp_data  in  BEAT_DW  beat data; word w at [w*WORD_W +: WORD_W]
- o_da_wr_valid / i_da_wr_ready  out/in  1  data-array write handshake
- o_da_wr_set, o_da_wr_way, o_da_wr_beat, o_da_wr_data  out  SET_W, WAY_W, BEAT_W, BEAT_DW  data-array write
- o_tag_wr_valid / i_tag_wr_ready  out/in  1  tag/status write handshake
- o_tag_wr_set, o_tag_wr_way, o_tag_wr_tag  out  SET_W, WAY_W, TAG_W  tag write; the receiving side sets valid and makes the way MRU
- o_missed_word, o_missed_word_valid  out  WORD_W, 1  early-restart word, one-cycle pulse
- o_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, REQ, FILL, TAG.
- IDLE: o_miss_ready = ~i_halt. On accept, latch tag, set and offset. Latch the victim way: the lowest index with i_way_valid=0, else i_lru_way. Compute crit_beat = offset[OFF_W-1:log2(BEAT_WORDS)]. Go to REQ.
- REQ: hold o_mem_req_valid=1 with o_mem_req_addr = {tag, set, start_beat, zeros}. On i_mem_req_ready, clear beat count and go to FILL.
- FILL: o_mem_rsp_ready = ~i_halt & (~o_da_wr_valid | i_da_wr_ready).
  - Memory returns BEATS beats in wrap order start_beat, start_beat+1, … modulo BEATS.
  - On each accepted beat, register the data-array write for the next cycle with o_da_wr_beat = (start_beat+count) mod BEATS. Hold it until i_da_wr_ready.
  - If the accepted beat index equals crit_beat, register o_missed_word (word offset[log2(BEAT_WORDS)-1:0] of that beat) and pulse o_missed_word_valid next cycle.
  - After the BEATS-th beat is accepted and its data-array write has completed, go to TAG.
- TAG: hold o_tag_wr_valid until i_tag_wr_ready, then go to IDLE.
- i_halt=1: no state, counter or register changes; held valids and data stay stable; no handshake completes. A pending missed-word pulse is delayed until the first non-halted cycle.
- Reset (any time, including mid-burst): state IDLE. All outputs 0 except o_miss_ready, which is 1 whenever i_halt=0. Beats still in flight at the memory are the memory side's responsibility.
- No beat is dropped or duplicated under data-array back-pressure. The beat counter wraps modulo BEATS. The 2^BEAT_W wrap is exact because BEATS is a power of 2.

## Timing
- Miss accepted at cycle 0 → o_mem_req_valid at cycle 1.
- Beat accepted at cycle N → o_da_wr_valid at N+1; o_missed_word_valid at N+1 for the critical beat.
- Last data-array write done at cycle M → o_tag_wr_valid at M+1. Tag write done at K → o_miss_ready at K+1.
- With zero memory latency and no stalls, the critical word arrives 3 cycles after miss accept when the critical-word-first feature is compiled in.
- Throughput: one beat per cycle while i_da_wr_ready=1.

## Configuration
- MISS_HANDLER_CWF_EN defined: start_beat = crit_beat (critical-word-first wrap burst).
- Not defined: start_beat = 0, in-order burst. The missed word is still forwarded when beat crit_beat arrives, and o_mem_req_addr low OFF_W bits are 0.

## Test plan
- CWF on, defaults, miss tag 0xA5, set 0x3, offset 0xB, way_valid 4'b1111, lru 2 → req addr 0xA53A; beats 5,6,7,0..4 to way 2; missed word = bits [39:20] of first beat, one cycle after it.
- way_valid 4'b1011, lru 0 → all writes and tag write to way 2.
- CWF off, same miss → req addr 0xA530; beat order 0..7; missed word pulse follows beat 5.
- i_da_wr_ready low for 3 cycles mid-burst and i_mem_rsp_valid always high → all 8 beats written once, in order, data intact.
- i_halt high for 4 cycles during FILL and TAG → outputs frozen; sequence resumes unchanged.
- arst_n pulsed low after beat 3 → all outputs 0; o_miss_ready=1 next cycle; a fresh miss completes normally.
